// File: rtl/piece_position_controller.sv
// rtl/piece_position_controller.sv - falling-piece position, colour and landing control for the VGA controller
//
// Debounces the left/right/down buttons, collects the accepted presses
// during a frame, and commits every position change in one cycle after the
// vsync falling edge. This keeps the VGA controller from drawing a half-moved piece.
//
// Ports:
//   Clock         pixel clock shared with the VGA controller
//   Reset         synchronous, active-high
//   iBtnLeft      raw asynchronous button, active-high
//   iBtnRight     raw asynchronous button, active-high
//   iBtnDown      raw asynchronous button, active-high
//   iVsync        vsync from the VGA controller, low during sync
//   oXRedCounter  X offset of the piece (10 bits)
//   oYRedCounter  Y offset of the piece (10 bits)
//   oColorCuadro  RGB colour of the piece (3 bits)
//   oLanded       one-cycle pulse, aligned with the position reset after a landing
//   oPieceCount   landed pieces, wraps 255->0
module piece_position_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRAVITY_FRAMES  = 30,
  parameter int STEP            = 32,
  parameter int X_START         = 128,
  parameter int X_MAX           = 288,
  parameter int Y_MAX           = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iBtnLeft,
  input  logic       iBtnRight,
  input  logic       iBtnDown,
  input  logic       iVsync,
  output logic [9:0] oXRedCounter,
  output logic [9:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oLanded,
  output logic [7:0] oPieceCount
);

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  GRAV_LAST = 8'(GRAVITY_FRAMES - 1);
  localparam logic [9:0]  STEP_W    = 10'(STEP);
  localparam logic [9:0]  XSTART_W  = 10'(X_START);
  localparam logic [9:0]  XMAX_W    = 10'(X_MAX);
  localparam logic [9:0]  YMAX_W    = 10'(Y_MAX);

  // Button index: 0 = left, 1 = right, 2 = down.
  localparam int BL = 0;
  localparam int BR = 1;
  localparam int BD = 2;

  typedef enum logic [1:0] {RUN, APPLY, LAND} state_t;

  logic [2:0]  btn_raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  stable;
  logic [2:0]  press;
  logic [19:0] db_cnt [3];
  logic [2:0]  pend;
  logic        vs_prev;
  logic        frame_tick;

  state_t      state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic [9:0]  x_d, y_d;
  logic [2:0]  color_d;
  logic [7:0]  count_d;
  logic        landed_d;
  logic        grav;
  logic        move_left;
  logic        move_right;

  assign btn_raw    = {iBtnDown, iBtnRight, iBtnLeft};
  assign frame_tick = vs_prev & ~iVsync;

  // Synchronizers and stable values reset to 1. A button that is low after reset
  // then settles to 0 without a press, so reset never creates a spurious press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  // A press that lands in the same cycle as APPLY survives the clear, so it is
  // applied on the next frame.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend    <= '0;
      vs_prev <= 1'b1;
    end else begin
      pend    <= press | ((state_q == APPLY) ? 3'b000 : pend);
      vs_prev <= iVsync;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= RUN;
      frame_q      <= '0;
      oXRedCounter <= XSTART_W;
      oYRedCounter <= '0;
      oColorCuadro <= 3'b100;
      oLanded      <= 1'b0;
      oPieceCount  <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      oXRedCounter <= x_d;
      oYRedCounter <= y_d;
      oColorCuadro <= color_d;
      oLanded      <= landed_d;
      oPieceCount  <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    x_d        = oXRedCounter;
    y_d        = oYRedCounter;
    color_d    = oColorCuadro;
    count_d    = oPieceCount;
    landed_d   = 1'b0;
    grav       = 1'b0;
    move_left  = pend[BL] & ~pend[BR];
    move_right = pend[BR] & ~pend[BL];

    case (state_q)
      RUN: begin
        if (frame_tick) state_d = APPLY;
      end

      APPLY: begin
        grav    = (frame_q == GRAV_LAST);
        frame_d = grav ? 8'd0 : frame_q + 8'd1;

        // Bounds are tested before the arithmetic so X never wraps.
        if (move_left && (oXRedCounter >= STEP_W))
          x_d = oXRedCounter - STEP_W;
        else if (move_right && (oXRedCounter < XMAX_W))
          x_d = oXRedCounter + STEP_W;

        state_d = RUN;
        if (pend[BD] || grav) begin
          if (oYRedCounter < YMAX_W)
            y_d = oYRedCounter + STEP_W;
          else
            state_d = LAND;
        end
      end

      LAND: begin
        landed_d = 1'b1;
        x_d      = XSTART_W;
        y_d      = '0;
        count_d  = oPieceCount + 8'd1;
        state_d  = RUN;
        case (oColorCuadro)
          3'b100:  color_d = 3'b010;
          3'b010:  color_d = 3'b001;
          3'b001:  color_d = 3'b110;
          3'b110:  color_d = 3'b011;
          3'b011:  color_d = 3'b101;
          default: color_d = 3'b100;
        endcase
      end

      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_piece_position_controller.sv
// tb/tb_piece_position_controller.sv - self-checking bench for piece_position_controller
`timescale 1ns/1ps
module tb_piece_position_controller;

  localparam int DB = 4;
  localparam int XS = 128;
  localparam int XM = 288;
  localparam int YM = 64;
  localparam int ST = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic bl = 1'b0, br = 1'b0, bd = 1'b0, vs = 1'b1;

  logic [9:0] ox [2];
  logic [9:0] oy [2];
  logic [2:0] oc [2];
  logic       ol [2];
  logic [7:0] on [2];

  always #5 Clock = ~Clock;

  // Instance 0 falls fast for gravity/landing checks; instance 1 almost never
  // falls, which leaves room to walk the piece to both X limits.
  piece_position_controller #(
    .DEBOUNCE_CYCLES(DB), .GRAVITY_FRAMES(2),
    .STEP(ST), .X_START(XS), .X_MAX(XM), .Y_MAX(YM)
  ) dut_fast (
    .Clock(Clock), .Reset(Reset),
    .iBtnLeft(bl), .iBtnRight(br), .iBtnDown(bd), .iVsync(vs),
    .oXRedCounter(ox[0]), .oYRedCounter(oy[0]), .oColorCuadro(oc[0]),
    .oLanded(ol[0]), .oPieceCount(on[0])
  );

  piece_position_controller #(
    .DEBOUNCE_CYCLES(DB), .GRAVITY_FRAMES(255),
    .STEP(ST), .X_START(XS), .X_MAX(XM), .Y_MAX(YM)
  ) dut_slow (
    .Clock(Clock), .Reset(Reset),
    .iBtnLeft(bl), .iBtnRight(br), .iBtnDown(bd), .iVsync(vs),
    .oXRedCounter(ox[1]), .oYRedCounter(oy[1]), .oColorCuadro(oc[1]),
    .oLanded(ol[1]), .oPieceCount(on[1])
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: piece state per instance, updated once per frame.
  int gv [2];
  int m_x [2], m_y [2], m_col [2], m_cnt [2], m_fc [2];
  bit m_land [2];
  bit pl, pr, pd;
  int land_seen [2];
  logic [2:0] ctab [6];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = XS; m_y[i] = 0; m_col[i] = 0; m_cnt[i] = 0; m_fc[i] = 0; m_land[i] = 0;
    end
    pl = 0; pr = 0; pd = 0;
  endtask

  task automatic model_frame();
    bit grav;
    for (int i = 0; i < 2; i++) begin
      m_fc[i]++;
      grav = (m_fc[i] % gv[i]) == 0;
      m_land[i] = 0;
      if (pl && !pr && m_x[i] > 0) m_x[i] -= ST;
      else if (pr && !pl && m_x[i] < XM) m_x[i] += ST;
      if (pd || grav) begin
        if (m_y[i] < YM) m_y[i] += ST;
        else begin
          m_land[i] = 1; m_x[i] = XS; m_y[i] = 0;
          m_cnt[i] = (m_cnt[i] + 1) % 256;
          m_col[i] = (m_col[i] + 1) % 6;
        end
      end
    end
    pl = 0; pr = 0; pd = 0;
  endtask

  function automatic logic [31:0] model_vec(input int i);
    return {10'(m_x[i]), 10'(m_y[i]), ctab[m_col[i]], 1'b0, 8'(m_cnt[i])};
  endfunction

  function automatic logic [31:0] dut_vec(input int i);
    return {ox[i], oy[i], oc[i], ol[i], on[i]};
  endfunction

  task automatic do_reset();
    @(negedge Clock); Reset = 1; bl = 0; br = 0; bd = 0; vs = 1;
    repeat (3) @(negedge Clock);
    Reset = 0;
    model_reset();
    repeat (10) @(negedge Clock);
  endtask

  // Hold long enough to be accepted, release long enough to settle.
  task automatic press(input int b);
    @(negedge Clock);
    if (b == 0) bl = 1; else if (b == 1) br = 1; else bd = 1;
    repeat (DB + 6) @(negedge Clock);
    bl = 0; br = 0; bd = 0;
    repeat (DB + 6) @(negedge Clock);
    if (b == 0) pl = 1; else if (b == 1) pr = 1; else pd = 1;
  endtask

  task automatic run_frame();
    @(negedge Clock); vs = 0;
    @(negedge Clock); vs = 1;
    model_frame();
    land_seen[0] = 0; land_seen[1] = 0;
    repeat (3) begin
      @(negedge Clock);
      for (int i = 0; i < 2; i++) if (ol[i]) land_seen[i]++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (dut_vec(i) !== {10'd128, 10'd0, 3'b100, 1'b0, 8'd0}) begin
        mismatched++;
        $display("FAIL reset_state[%0d]: got %h expected %h", i, dut_vec(i), {10'd128, 10'd0, 3'b100, 1'b0, 8'd0});
      end
    end
    repeat (20) @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL idle_no_vsync[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
  endtask

  task automatic test_move_right();
    press(1);
    @(negedge Clock); vs = 0;
    @(negedge Clock); vs = 1;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (ox[i] !== 10'(m_x[i])) begin
        mismatched++;
        $display("FAIL right_too_early[%0d]: got %0d expected %0d", i, ox[i], m_x[i]);
      end
    end
    model_frame();
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (ox[i] !== 10'd160 || dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL right_applied[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
    repeat (2) @(negedge Clock);
    run_frame();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL no_repeat_press[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
  endtask

  task automatic test_glitch_and_both();
    repeat (8) begin
      @(negedge Clock); bl = 1;
      @(negedge Clock); bl = 0;
      @(negedge Clock);
    end
    repeat (10) @(negedge Clock);
    run_frame();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL glitch_ignored[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
    press(0);
    press(1);
    run_frame();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL left_and_right[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    for (int f = 0; f < 15; f++) begin
      press(f < 5 ? 0 : 1);
      run_frame();
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (dut_vec(i) !== model_vec(i) || land_seen[i] != int'(m_land[i])) begin
          mismatched++;
          $display("FAIL boundary_frame%0d[%0d]: got %h land %0d expected %h land %0d",
                   f, i, dut_vec(i), land_seen[i], model_vec(i), m_land[i]);
        end
      end
      if (f == 4) begin
        compared++;
        if (ox[1] !== 10'd0) begin
          mismatched++;
          $display("FAIL left_clamp: got %0d expected 0", ox[1]);
        end
      end
    end
    compared++;
    if (ox[1] !== 10'd288) begin
      mismatched++;
      $display("FAIL right_clamp: got %0d expected 288", ox[1]);
    end
  endtask

  task automatic test_gravity_land();
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      run_frame();
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (dut_vec(i) !== model_vec(i) || land_seen[i] != int'(m_land[i])) begin
          mismatched++;
          $display("FAIL gravity_frame%0d[%0d]: got %h land %0d expected %h land %0d",
                   f, i, dut_vec(i), land_seen[i], model_vec(i), m_land[i]);
        end
      end
    end
    compared++;
    if ({land_seen[0] == 1, oy[0], ox[0], oc[0], on[0]} !== {1'b1, 10'd0, 10'd128, 3'b010, 8'd1}) begin
      mismatched++;
      $display("FAIL first_landing: got land %0d y %0d x %0d col %b cnt %0d expected land 1 y 0 x 128 col 010 cnt 1",
               land_seen[0], oy[0], ox[0], oc[0], on[0]);
    end
  endtask

  task automatic test_reset_discards();
    press(2);
    @(negedge Clock); Reset = 1;
    @(negedge Clock); Reset = 0; vs = 0;
    model_reset();
    @(negedge Clock); vs = 1;
    model_frame();
    repeat (3) @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (oy[i] !== 10'd0 || dut_vec(i) !== model_vec(i)) begin
        mismatched++;
        $display("FAIL reset_discard[%0d]: got %h expected %h", i, dut_vec(i), model_vec(i));
      end
    end
    repeat (10) @(negedge Clock);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      for (int b = 0; b < 3; b++) begin
        int n;
        n = $urandom_range(0, 3);
        if (n >= 2) press(b);
        if (n == 3) press(b);
      end
      run_frame();
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (dut_vec(i) !== model_vec(i) || land_seen[i] != int'(m_land[i])) begin
          mismatched++;
          $display("FAIL random_frame%0d[%0d]: got %h land %0d expected %h land %0d",
                   f, i, dut_vec(i), land_seen[i], model_vec(i), m_land[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int landings;
    int guard;
    do_reset();
    landings = 0;
    guard = 0;
    while (landings < 256 && guard < 3000) begin
      run_frame();
      guard++;
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (land_seen[i] != int'(m_land[i]) || on[i] !== 8'(m_cnt[i])) begin
          mismatched++;
          $display("FAIL wrap_frame%0d[%0d]: got land %0d cnt %0d expected land %0d cnt %0d",
                   guard, i, land_seen[i], on[i], m_land[i], m_cnt[i]);
        end
      end
      if (m_land[0]) landings++;
    end
    compared++;
    if (landings != 256 || on[0] !== 8'd0 || dut_vec(0) !== model_vec(0)) begin
      mismatched++;
      $display("FAIL count_wrap: got landings %0d cnt %0d state %h expected landings 256 cnt 0 state %h",
               landings, on[0], dut_vec(0), model_vec(0));
    end
  endtask

  initial begin
    gv[0] = 2;
    gv[1] = 255;
    ctab[0] = 3'b100; ctab[1] = 3'b010; ctab[2] = 3'b001;
    ctab[3] = 3'b110; ctab[4] = 3'b011; ctab[5] = 3'b101;
    model_reset();
    test_reset();
    test_move_right();
    test_glitch_and_both();
    test_boundaries();
    test_gravity_land();
    test_reset_discards();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
